// File: rtl/ha_array_row_sequencer.sv
// Row-serial reduction controller for the 8x8 approximate multiplier's half-adder array.
// Optional build macro: HA_SEQ_BIAS_EN adds a BIAS state that folds in the BIAS constant once.
module ha_array_row_sequencer #(
    parameter int ROWS      = 4,
    parameter int ROW_SHIFT = 2,
    parameter int OUT_W     = 16
`ifdef HA_SEQ_BIAS_EN
    , parameter logic [OUT_W-1:0] BIAS = '0
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           x,
    input  logic [7:0]           y,
    output logic [7:0]           arr_x,
    output logic [7:0]           arr_y,
    input  logic [7*ROWS-1:0]    ha_b,
    input  logic [9*ROWS-1:0]    ha_t,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_p,
    output logic                 busy
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

`ifdef HA_SEQ_BIAS_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_DONE = 2'd2, S_BIAS = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_DONE = 2'd2} state_t;
`endif

    state_t           state, state_nxt;
    logic [RW-1:0]    row;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] t_sh [ROWS];
    logic [OUT_W-1:0] b_sh [ROWS];
    logic [OUT_W-1:0] add_a, add_b, acc_sum;

    // Row alignment is pure wiring; only the selected row reaches the shared adder.
    for (genvar k = 0; k < ROWS; k++) begin : g_row
        assign t_sh[k] = OUT_W'(ha_t[9*k +: 9]) << (ROW_SHIFT * k);
        assign b_sh[k] = OUT_W'(ha_b[7*k +: 7]) << (ROW_SHIFT * k + 2);
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        add_a = t_sh[row];
        add_b = b_sh[row];
`ifdef HA_SEQ_BIAS_EN
        if (state == S_BIAS) begin
            add_a = BIAS;
            add_b = '0;
        end
`endif
    end

    // Single three-operand adder; overflow beyond OUT_W bits is intentionally dropped.
    assign acc_sum = acc + add_a + add_b;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) state_nxt = S_ACC;
            S_ACC: begin
                if (row == LAST_ROW) begin
`ifdef HA_SEQ_BIAS_EN
                    state_nxt = S_BIAS;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef HA_SEQ_BIAS_EN
            S_BIAS: state_nxt = S_DONE;
`endif
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the datapath is plain flops (no memory), so all of it is reset to a known zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_x <= '0;
            arr_y <= '0;
            acc   <= '0;
            row   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        arr_x <= x;
                        arr_y <= y;
                        acc   <= '0;
                        row   <= '0;
                    end
                end
                S_ACC: begin
                    acc <= acc_sum;
                    row <= row + 1'b1;
                end
`ifdef HA_SEQ_BIAS_EN
                S_BIAS: acc <= acc_sum;
`endif
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_p     = acc;

endmodule

// File: tb/tb_ha_array_row_sequencer.sv
// Self-checking bench for ha_array_row_sequencer: a stub array drives held row vectors
// and a bit-weight reference model predicts each product.
module tb_ha_array_row_sequencer;

    localparam int ROWS = 4;
`ifdef HA_SEQ_BIAS_EN
    localparam int     LAT     = 6;
    localparam int     SPACING = 7;
`else
    localparam int     LAT     = 5;
    localparam int     SPACING = 6;
`endif
    localparam longint TB_BIAS = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  x = '0, y = '0;
    logic [7:0]  arr_x, arr_y;
    logic [27:0] ha_b = '0;
    logic [35:0] ha_t = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_p;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    ha_array_row_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .arr_x(arr_x), .arr_y(arr_y),
        .ha_b(ha_b), .ha_t(ha_t),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
        $fatal(1);
    end

    // Reference: every set bit contributes 2^weight, summed then reduced modulo 2^16.
    function automatic logic [15:0] model(input logic [35:0] tv, input logic [27:0] bv);
        longint s = 0;
        for (int k = 0; k < ROWS; k++) begin
            for (int i = 0; i < 9; i++)
                if (tv[9*k+i]) s += longint'(1) << (2*k + i);
            for (int i = 0; i < 7; i++)
                if (bv[7*k+i]) s += longint'(1) << (2*k + i + 2);
        end
`ifdef HA_SEQ_BIAS_EN
        s += TB_BIAS;
`endif
        return 16'(s);
    endfunction

    // Accept one operand pair, wait for the product, hold it for 'hold' cycles, then release.
    task automatic run_op(input logic [7:0] xv, input logic [7:0] yv,
                          input logic [35:0] tv, input logic [27:0] bv,
                          input int hold, input string name);
        logic [15:0] exp_p;
        int n;
        exp_p = model(tv, bv);
        ha_t = tv; ha_b = bv; x = xv; y = yv;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s idle_ready: got %b want 1", name, in_ready);
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        n = 1;
        // Keep in_valid high with different operands while busy; they must be ignored.
        x = ~xv; y = ~yv;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (n !== LAT) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d want %0d", name, n, LAT);
        end
        tests_run++;
        if (out_p !== exp_p) begin
            tests_failed++;
            $display("FAIL %s product: got %h want %h", name, out_p, exp_p);
        end
        tests_run++;
        if (arr_x !== xv || arr_y !== yv) begin
            tests_failed++;
            $display("FAIL %s arr_xy: got %h/%h want %h/%h", name, arr_x, arr_y, xv, yv);
        end
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_p !== exp_p || in_ready !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s hold%0d: got v=%b p=%h rdy=%b busy=%b want v=1 p=%h rdy=0 busy=1",
                         name, c, out_valid, out_p, in_ready, busy, exp_p);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || arr_x !== xv) begin
            tests_failed++;
            $display("FAIL %s release: got rdy=%b v=%b arr_x=%h want rdy=1 v=0 arr_x=%h",
                     name, in_ready, out_valid, arr_x, xv);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_p !== 16'h0000
            || arr_x !== 8'h00 || arr_y !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b v=%b busy=%b p=%h ax=%h ay=%h want 1 0 0 0000 00 00",
                     in_ready, out_valid, busy, out_p, arr_x, arr_y);
        end
    endtask

    task automatic test_boundaries;
        run_op(8'h12, 8'h34, 36'h0_0000_0001, 28'h0, 0, "row0_lsb");
        tests_run++;
        if (out_p !== 16'h0001) begin
            tests_failed++;
            $display("FAIL row0_lsb_const: got %h want 0001", out_p);
        end
        run_op(8'hA5, 8'h5A, 36'h1 << 35, 28'h1 << 27, 0, "row3_msb");
        tests_run++;
        if (out_p !== 16'h8000) begin
            tests_failed++;
            $display("FAIL row3_msb_const: got %h want 8000", out_p);
        end
        run_op(8'hFF, 8'hFF, '1, '1, 0, "all_ones");
        tests_run++;
        if ($isunknown(out_p)) begin
            tests_failed++;
            $display("FAIL all_ones_x: got %h want no X", out_p);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 10; i++)
            run_op(8'($urandom), 8'($urandom), 36'({$urandom(), $urandom()}),
                   28'($urandom), 0, $sformatf("rand%0d", i));
    endtask

    task automatic test_backpressure;
        run_op(8'($urandom), 8'($urandom), 36'({$urandom(), $urandom()}),
               28'($urandom), 10, "backpressure");
    endtask

    task automatic test_back_to_back;
        logic [35:0] tv;
        logic [27:0] bv;
        logic [15:0] exp_p;
        int prev, nprod;
        bit saw;
        tv = 36'({$urandom(), $urandom()});
        bv = 28'($urandom);
        exp_p = model(tv, bv);
        ha_t = tv; ha_b = bv; x = 8'h3C; y = 8'hC3;
        in_valid = 1'b1; out_ready = 1'b1;
        prev = -1; nprod = 0; saw = 1'b0;
        for (int c = 0; c < 60 && nprod < 3; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                tests_run++;
                if (out_p !== exp_p) begin
                    tests_failed++;
                    $display("FAIL b2b_product%0d: got %h want %h", nprod, out_p, exp_p);
                end
                if (prev >= 0) begin
                    tests_run++;
                    if (c - prev !== SPACING) begin
                        tests_failed++;
                        $display("FAIL b2b_spacing%0d: got %0d want %0d", nprod, c - prev, SPACING);
                    end
                end
                prev = c; nprod++; saw = 1'b1;
            end else if (saw) begin
                tests_run++;
                if (in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_ready: got %b want 1", in_ready);
                end
                saw = 1'b0;
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (nprod !== 3) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d want 3", nprod);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: got rdy=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_acc;
        ha_t = '1; ha_b = '1; x = 8'h77; y = 8'h88;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        tests_run++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midacc_pre: got busy=%b v=%b want 1 0", busy, out_valid);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_p !== 16'h0
            || arr_x !== 8'h00) begin
            tests_failed++;
            $display("FAIL midacc_reset: got rdy=%b busy=%b v=%b p=%h ax=%h want 1 0 0 0000 00",
                     in_ready, busy, out_valid, out_p, arr_x);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL midacc_quiet%0d: got v=%b rdy=%b want 0 1", c, out_valid, in_ready);
            end
        end
        run_op(8'($urandom), 8'($urandom), 36'({$urandom(), $urandom()}),
               28'($urandom), 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_boundaries();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_acc();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
